spu_logical_imm_pipe: RTL and testbench

Pipelined, parametrised successor to the SPU even-pipe halfword AND-immediate. Covers the whole SPU logical-immediate family (AND/OR/XOR with byte, halfword and word immediates) plus the register-register logical ops, over a configurable datapath width. Adds a LAT-deep valid/ready elastic pipeline with flush and a destination-tag sideband. Sits in the even pipeline between operand fetch and the register-file writeback arbiter.

---
 rtl/spu_alu_pkg.sv | 73 +++++++
 rtl/spu_pipe_stage.sv | 54 +++++
 rtl/spu_logical_imm_pipe.sv | 130 +++++++++++++
 tb/tb_spu_logical_imm_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spu_alu_pkg.sv
// Shared definitions for the SPU logical-immediate pipeline.
//   op_e       : logical operation codes (3 bits)
//   esize_e    : immediate element size (2 bits)
//   expand_imm : builds the replicated immediate operand
package spu_alu_pkg;

  // Upper bounds used to size the expand_imm interface.
  // Callers truncate the return value to their own DATA_W.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_IMM_W  = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_EQV  = 3'd5,
    OP_ANDC = 3'd6,
    OP_ORC  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ES_BYTE = 2'd0,
    ES_HALF = 2'd1,
    ES_WORD = 2'd2,
    ES_ILL  = 2'd3
  } esize_e;

  // Expands an imm_w-bit immediate, supplied zero-padded, into one element.
  // A byte element takes the low 8 bits unchanged. A halfword or word element
  // sign-extends from bit imm_w-1. The element is then replicated across the
  // low data_w bits, and any bits above data_w are zero. The illegal size
  // gives an all-zero operand.
  function automatic logic [MAX_DATA_W-1:0] expand_imm(
    input logic [MAX_IMM_W-1:0] imme,
    input int                   imm_w,
    input esize_e               esize,
    input int                   data_w
  );
    logic [MAX_DATA_W-1:0] rep;
    logic [31:0]           elem;
    logic                  sign;
    int                    elem_w;
    elem   = 32'h0000_0000;
    elem_w = 32;
    sign   = imme[5'(imm_w - 1)];
    case (esize)
      ES_BYTE: begin
        elem_w = 8;
        for (int i = 0; i < 8; i++) elem[5'(i)] = imme[5'(i)];
      end
      ES_HALF: begin
        elem_w = 16;
        for (int i = 0; i < 16; i++) elem[5'(i)] = (i < imm_w) ? imme[5'(i)] : sign;
      end
      ES_WORD: begin
        elem_w = 32;
        for (int i = 0; i < 32; i++) elem[5'(i)] = (i < imm_w) ? imme[5'(i)] : sign;
      end
      default: begin
        elem_w = 32;
        elem   = 32'h0000_0000;
      end
    endcase
    rep = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      rep[9'(i)] = (i < data_w) ? elem[5'(i % elem_w)] : 1'b0;
    end
    return rep;
  endfunction

endpackage

// File: rtl/spu_pipe_stage.sv
// One register slice of the elastic pipeline.
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : synchronous clear of the valid bit
//   load       : the slot is free or is being drained this cycle
//   in_valid   : upstream valid
//   in_data    : upstream payload
//   valid      : registered valid bit
//   data       : registered payload
// The enclosing pipeline computes the ready chain from all the valid bits.
// This keeps the slice free of any combinational path.
module spu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Valid bit: flush wins; otherwise follow upstream whenever the slot loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= in_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: captured only for a real transfer, so a stalled or idle slot holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (load && in_valid && !flush) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/spu_logical_imm_pipe.sv
// SPU logical / logical-immediate unit with a LAT-deep valid/ready pipeline.
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush               : kills all in-flight ops and refuses input this cycle
//   in_valid / in_ready : input handshake
//   op, use_imm, esize  : operation, operand-b select, immediate element size
//   ra, rb, imme        : operands and immediate
//   in_tag              : destination tag carried with the op
//   out_valid/out_ready : output handshake
//   result, out_tag     : result and its tag
//   out_err             : op used an immediate with the illegal element size
// The result is computed at the input. It then travels with its tag and error
// bit through LAT register slices.
module spu_logical_imm_pipe
  import spu_alu_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int IMM_W  = 10,
  parameter int TAG_W  = 7,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              use_imm,
  input  logic [1:0]        esize,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] rb,
  input  logic [IMM_W-1:0]  imme,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int SLICE_W = DATA_W + TAG_W + 1;

  logic [DATA_W-1:0]  imm_rep_s;
  logic [DATA_W-1:0]  opb_s;
  logic [DATA_W-1:0]  alu_s;
  logic [DATA_W-1:0]  res_s;
  logic               err_s;
  logic [SLICE_W-1:0] slice_in_s;
  logic [LAT-1:0]     vld_s;
  logic [LAT-1:0]     load_s;
  logic [SLICE_W-1:0] dat_s [0:LAT-1];

  // Operand b selection and illegal-size detection.
  always_comb begin
    imm_rep_s = DATA_W'(expand_imm(MAX_IMM_W'(imme), IMM_W, esize_e'(esize), DATA_W));
    if (use_imm) begin
      opb_s = imm_rep_s;
      err_s = (esize_e'(esize) == ES_ILL);
    end else begin
      opb_s = rb;
      err_s = 1'b0;
    end
  end

  // Logical operation mux; an erroneous op is forced to a zero result.
  always_comb begin
    alu_s = '0;
    case (op_e'(op))
      OP_AND:  alu_s = ra & opb_s;
      OP_OR:   alu_s = ra | opb_s;
      OP_XOR:  alu_s = ra ^ opb_s;
      OP_NAND: alu_s = ~(ra & opb_s);
      OP_NOR:  alu_s = ~(ra | opb_s);
      OP_EQV:  alu_s = ~(ra ^ opb_s);
      OP_ANDC: alu_s = ra & ~opb_s;
      OP_ORC:  alu_s = ra | ~opb_s;
      default: alu_s = '0;
    endcase
    if (err_s) begin
      res_s = '0;
    end else begin
      res_s = alu_s;
    end
  end

  assign slice_in_s = {err_s, in_tag, res_s};

  // Load enables: stage k can take new data when the output drains this cycle
  // or when some stage from k to the last one is empty. The stages then shift
  // up to close the bubble. This is built from registered valid bits only.
  always_comb begin
    logic all_v;
    load_s = '0;
    all_v  = 1'b1;
    for (int k = LAT - 1; k >= 0; k--) begin
      all_v     = all_v & vld_s[k];
      load_s[k] = out_ready | ~all_v;
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_first
      spu_pipe_stage #(.W(SLICE_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (load_s[k]),
        .in_valid (in_valid),
        .in_data  (slice_in_s),
        .valid    (vld_s[k]),
        .data     (dat_s[k])
      );
    end else begin : g_next
      spu_pipe_stage #(.W(SLICE_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (load_s[k]),
        .in_valid (vld_s[k-1]),
        .in_data  (dat_s[k-1]),
        .valid    (vld_s[k]),
        .data     (dat_s[k])
      );
    end
  end

  assign in_ready                    = load_s[0] & ~flush;
  assign out_valid                   = vld_s[LAT-1];
  assign {out_err, out_tag, result}  = dat_s[LAT-1];

endmodule

// File: tb/tb_spu_logical_imm_pipe.sv
module tb_spu_logical_imm_pipe;

  localparam int DATA_W = 128;
  localparam int IMM_W  = 10;
  localparam int TAG_W  = 7;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, use_imm;
  logic [2:0]        op;
  logic [1:0]        esize;
  logic [DATA_W-1:0] ra, rb, result;
  logic [IMM_W-1:0]  imme;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic              out_valid, out_ready, out_err;

  int checks = 0;
  int errors = 0;

  spu_logical_imm_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm), .esize(esize), .ra(ra), .rb(rb), .imme(imme),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for it to come out, check latency and payload.
  task automatic run_one(input string name, input logic [2:0] o, input logic ui,
                         input logic [1:0] es, input logic [127:0] a, input logic [127:0] b,
                         input logic [9:0] im, input logic [6:0] tg,
                         input logic [127:0] exp_res, input logic exp_err);
    int lat;
    op = o; use_imm = ui; esize = es; ra = a; rb = b; imme = im; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(LAT));
    check({name, "_valid"}, 128'(out_valid), 128'(1'b1));
    check({name, "_result"}, result, exp_res);
    check({name, "_tag"}, 128'(out_tag), 128'(tg));
    check({name, "_err"}, 128'(out_err), 128'(exp_err));
    step();
  endtask

  initial begin
    int sent, rcv, last_acc;
    logic acc;
    logic [127:0] exp_v;
    logic [127:0] reg_exp [0:7];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; use_imm = 1'b0; esize = 2'd0; ra = '0; rb = '0; imme = '0; in_tag = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state.
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_result", result, 128'h0);
    check("rst_out_tag", 128'(out_tag), 128'(7'h00));
    check("rst_out_err", 128'(out_err), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));

    // Halfword AND-immediate: every halfword masked with FFF0.
    run_one("hw_and", 3'd0, 1'b1, 2'd1, 128'h0123_4567_89AB_CDEF_FFFF_0000_1234_8000, 128'h0,
            10'h3F0, 7'h15, 128'h0120_4560_89A0_CDE0_FFF0_0000_1230_8000, 1'b0);

    // Byte and word expansion of the same immediate through OR with zero.
    run_one("byte_or", 3'd1, 1'b1, 2'd0, 128'h0, 128'h0, 10'h2AB, 7'h21, {16{8'hAB}}, 1'b0);
    run_one("word_or", 3'd1, 1'b1, 2'd2, 128'h0, 128'h0, 10'h2AB, 7'h22, {4{32'hFFFF_FEAB}}, 1'b0);
    run_one("half_or", 3'd1, 1'b1, 2'd1, 128'h0, 128'h0, 10'h2AB, 7'h23, {8{16'hFEAB}}, 1'b0);

    // Register form, all eight ops: a=F0F0.., b=FF00..
    reg_exp[0] = {8{16'hF000}};
    reg_exp[1] = {8{16'hFFF0}};
    reg_exp[2] = {8{16'h0FF0}};
    reg_exp[3] = {8{16'h0FFF}};
    reg_exp[4] = {8{16'h000F}};
    reg_exp[5] = {8{16'hF00F}};
    reg_exp[6] = {8{16'h00F0}};
    reg_exp[7] = {8{16'hF0FF}};
    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("reg_op%0d", i), 3'(i), 1'b0, 2'd3, {16{8'hF0}}, {8{16'hFF00}},
              10'h3FF, 7'(i + 40), reg_exp[i], 1'b0);
    end

    // Illegal element size, then a legal one right after.
    run_one("ill_esize", 3'd1, 1'b1, 2'd3, {128{1'b1}}, 128'h0, 10'h155, 7'h30, 128'h0, 1'b1);
    run_one("after_ill", 3'd0, 1'b1, 2'd1, {128{1'b1}}, 128'h0, 10'h3F0, 7'h31, {8{16'hFFF0}}, 1'b0);

    // Backpressure: 10 back-to-back ops, output stalled for the first 6 cycles.
    sent = 0; rcv = 0; last_acc = -1;
    op = 3'd1; use_imm = 1'b0; rb = '0;
    for (int c = 0; c < 40 && (rcv < 10 || sent < 10); c++) begin
      out_ready = (c >= 6);
      in_valid  = (sent < 10);
      ra        = 128'(sent * 7 + 1);
      in_tag    = 7'(sent + 3);
      #1;
      if (c == 2) check("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
      if (c == 6) check("bp_accepts_before_release", 128'(sent), 128'(LAT));
      if (c >= 2 && c <= 5) check($sformatf("bp_hold_c%0d", c), result, 128'h1);
      if (c >= 6 && sent < 10) check($sformatf("bp_ready_c%0d", c), 128'(in_ready), 128'(1'b1));
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        exp_v = 128'(rcv * 7 + 1);
        check($sformatf("bp_res%0d", rcv), result, exp_v);
        check($sformatf("bp_tag%0d", rcv), 128'(out_tag), 128'(7'(rcv + 3)));
        rcv++;
      end
      step();
      if (acc) begin
        sent++;
        last_acc = c;
      end
    end
    in_valid = 1'b0;
    check("bp_received", 128'(rcv), 128'd10);
    check("bp_last_accept_cycle", 128'(last_acc), 128'd13);
    step();
    check("bp_drained", 128'(out_valid), 128'(1'b0));

    // Flush with the pipe full.
    out_ready = 1'b0; op = 3'd1; use_imm = 1'b0; rb = '0;
    for (int i = 0; i < LAT; i++) begin
      ra = 128'(i + 100); in_tag = 7'(i + 60); in_valid = 1'b1;
      step();
    end
    check("fl_full_valid", 128'(out_valid), 128'(1'b1));
    flush = 1'b1; in_valid = 1'b1; ra = 128'h77;
    #1;
    check("fl_in_ready_low", 128'(in_ready), 128'(1'b0));
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fl_no_valid%0d", i), 128'(out_valid), 128'(1'b0));
      step();
    end
    check("fl_in_ready_back", 128'(in_ready), 128'(1'b1));

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      ra = {128{1'b1}}; in_tag = 7'h7F; in_valid = 1'b1; use_imm = 1'b1; esize = 2'd3;
      step();
    end
    in_valid = 1'b0; use_imm = 1'b0; esize = 2'd0;
    check("rs_full_valid", 128'(out_valid), 128'(1'b1));
    check("rs_full_err", 128'(out_err), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_valid_now", 128'(out_valid), 128'(1'b0));
    check("rs_tag_now", 128'(out_tag), 128'(7'h00));
    check("rs_err_now", 128'(out_err), 128'(1'b0));
    check("rs_result_now", result, 128'h0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("rs_after_valid", 128'(out_valid), 128'(1'b0));
    check("rs_after_ready", 128'(in_ready), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
